// File: rtl/alu1_bit_msb.sv
// MSB slice of a ripple-carry ALU with registered result, carry, overflow and SLT set bit.
// Optional sticky overflow flag enabled by defining ALU1_BIT_MSB_STICKY_OVF_EN.
module alu1_bit_msb (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic lessinp,
  input  logic cin,
  input  logic ainv,
  input  logic binv,
  input  logic opcodeA,
  input  logic opcodeB,
  input  logic en,
`ifdef ALU1_BIT_MSB_STICKY_OVF_EN
  input  logic clr_sticky,
  output logic ovf_sticky,
`endif
  output logic cout,
  output logic result,
  output logic overflow,
  output logic slt
);

  logic [1:0] w_op;
  logic       w_a;
  logic       w_b;
  logic       w_sum;
  logic       w_co;
  logic       w_ovf;
  logic       w_set;
  logic       w_fn;

  logic       r_cout;
  logic       r_result;
  logic       r_overflow;
  logic       r_slt;

  assign w_op  = {opcodeA, opcodeB};
  assign w_a   = a ^ ainv;
  assign w_b   = b ^ binv;
  assign w_sum = w_a ^ w_b ^ cin;
  assign w_co  = (w_a & w_b) | (w_a & cin) | (w_b & cin);
  assign w_ovf = cin ^ w_co;
  assign w_set = w_sum ^ w_ovf;

  // Opcode 10 doubles as SLT when B is inverted (subtract in progress).
  always_comb begin
    w_fn = 1'b0;
    case (w_op)
      2'b00:   w_fn = w_a & w_b;
      2'b01:   w_fn = w_a | w_b;
      2'b10:   w_fn = binv ? lessinp : (w_a ^ w_b);
      default: w_fn = w_sum;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cout     <= 1'b0;
      r_result   <= 1'b0;
      r_overflow <= 1'b0;
      r_slt      <= 1'b0;
    end else if (en) begin
      r_cout     <= w_co;
      r_result   <= w_fn;
      r_overflow <= w_ovf;
      r_slt      <= w_set;
    end
  end

  assign cout     = r_cout;
  assign result   = r_result;
  assign overflow = r_overflow;
  assign slt      = r_slt;

`ifdef ALU1_BIT_MSB_STICKY_OVF_EN
  logic r_ovf_sticky;
  logic w_sticky_set;

  assign w_sticky_set = en & (w_op == 2'b11) & w_ovf;

  // Set has priority over clear when both occur on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_sticky <= 1'b0;
    end else if (w_sticky_set) begin
      r_ovf_sticky <= 1'b1;
    end else if (clr_sticky) begin
      r_ovf_sticky <= 1'b0;
    end
  end

  assign ovf_sticky = r_ovf_sticky;
`endif

endmodule

// File: tb/tb_alu1_bit_msb.sv
// Scoreboard bench for alu1_bit_msb: directed vectors push expectations, a monitor checks after each edge.
module tb_alu1_bit_msb;

  logic clk = 1'b0;
  logic rst;
  logic a, b, lessinp, cin, ainv, binv, opcodeA, opcodeB, en;
  logic clr_sticky;
  logic cout, result, overflow, slt;
`ifdef ALU1_BIT_MSB_STICKY_OVF_EN
  logic ovf_sticky;
`endif

  typedef struct {
    logic cout;
    logic result;
    logic overflow;
    logic slt;
    logic sticky;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alu1_bit_msb dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .lessinp  (lessinp),
    .cin      (cin),
    .ainv     (ainv),
    .binv     (binv),
    .opcodeA  (opcodeA),
    .opcodeB  (opcodeB),
    .en       (en),
`ifdef ALU1_BIT_MSB_STICKY_OVF_EN
    .clr_sticky (clr_sticky),
    .ovf_sticky (ovf_sticky),
`endif
    .cout     (cout),
    .result   (result),
    .overflow (overflow),
    .slt      (slt)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".cout"},     cout,     e.cout);
    chk({tag, ".result"},   result,   e.result);
    chk({tag, ".overflow"}, overflow, e.overflow);
    chk({tag, ".slt"},      slt,      e.slt);
`ifdef ALU1_BIT_MSB_STICKY_OVF_EN
    chk({tag, ".sticky"},   ovf_sticky, e.sticky);
`endif
  endtask

  // Monitor: one expectation per capture edge, sampled 1 ns after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_all("vec", e);
      end
    end
  end

  // Apply one vector at the falling edge and queue its hand-computed response.
  task automatic vec(input logic ia, input logic ib, input logic il, input logic ic,
                     input logic iai, input logic ibi, input logic [1:0] op,
                     input logic ie, input logic iclr,
                     input logic eco, input logic eres, input logic eovf,
                     input logic eslt, input logic estk);
    exp_t e;
    @(negedge clk);
    a = ia; b = ib; lessinp = il; cin = ic; ainv = iai; binv = ibi;
    opcodeA = op[1]; opcodeB = op[0]; en = ie; clr_sticky = iclr;
    e.cout = eco; e.result = eres; e.overflow = eovf; e.slt = eslt; e.sticky = estk;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t zero;
    int   budget;
    zero = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    rst = 1'b1;
    {a, b, lessinp, cin, ainv, binv, opcodeA, opcodeB, en, clr_sticky} = '0;
    #2;
    chk_all("reset", zero);
    @(negedge clk);
    rst = 1'b0;

    //  a  b  l  c ai bi  op    en clr | co res ovf slt stk
    vec(1, 0, 0, 0, 0, 0, 2'b00, 1, 0,   0, 0, 0, 1, 0); // AND
    vec(1, 0, 0, 0, 0, 0, 2'b01, 1, 0,   0, 1, 0, 1, 0); // OR
    vec(0, 1, 0, 0, 0, 0, 2'b10, 1, 0,   0, 1, 0, 1, 0); // XOR
    vec(1, 0, 0, 1, 0, 0, 2'b11, 1, 0,   1, 0, 0, 0, 0); // ADD
    vec(1, 1, 0, 1, 0, 1, 2'b11, 1, 0,   1, 0, 0, 0, 0); // SUB
    vec(0, 1, 0, 0, 0, 1, 2'b10, 1, 0,   0, 0, 0, 0, 0); // SLT less=0
    vec(0, 1, 0, 0, 1, 1, 2'b00, 1, 0,   0, 0, 0, 1, 0); // NOR
    vec(0, 0, 0, 1, 0, 0, 2'b11, 1, 0,   0, 1, 1, 0, 1); // pos overflow
    vec(1, 1, 0, 0, 0, 0, 2'b11, 1, 0,   1, 0, 1, 1, 1); // neg overflow
    vec(0, 0, 0, 0, 0, 0, 2'b00, 0, 0,   1, 0, 1, 1, 1); // hold
    vec(1, 1, 1, 1, 1, 1, 2'b01, 0, 0,   1, 0, 1, 1, 1); // hold
    vec(0, 1, 1, 1, 0, 1, 2'b10, 1, 0,   0, 1, 1, 0, 1); // SLT less=1
    vec(1, 1, 0, 1, 0, 0, 2'b10, 1, 1,   1, 0, 0, 1, 0); // XOR + clear sticky
    vec(0, 0, 0, 1, 0, 0, 2'b11, 1, 1,   0, 1, 1, 0, 1); // set beats clear

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (exp_q.size() > 0) chk("drain_timeout", 1'b1, 1'b0);

    // Asynchronous reset between edges, then hold reset across an enabled edge.
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk_all("async_rst", zero);
    vec(1, 1, 0, 0, 0, 0, 2'b11, 1, 0,   0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b1});

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #3;
    if (exp_q.size() > 0) chk("drain_timeout", 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu1_bit_msb.md
Name: alu1_bit_msb

Overview:
- Most-significant-bit slice of a ripple-carry 32-bit ALU.
- Computes AND/OR/XOR/ADD/SUB/NOR/SLT on one bit pair, with operand inversion and carry-in from the lower slice.
- Also produces the MSB-only flags: signed overflow and the SLT "set" bit, which is routed back to bit 0's less input.
- All outputs are registered: one clock of latency.

Parameters:
- None.

Ports:
- clk       input   1  rising-edge clock
- rst       input   1  reset; asynchronous, active-high
- a         input   1  operand A bit 31
- b         input   1  operand B bit 31
- lessinp   input   1  less input; selected in SLT mode (tied 0 at MSB in the 32-bit ALU)
- cin       input   1  carry-in from bit 30
- ainv      input   1  invert A before the function
- binv      input   1  invert B before the function
- opcodeA   input   1  function select, high bit
- opcodeB   input   1  function select, low bit
- en        input   1  register load enable
- cout      output  1  registered carry-out of a'+b'+cin
- result    output  1  registered function result
- overflow  output  1  registered signed overflow, cin XOR carry-out
- slt       output  1  registered set bit, sum XOR overflow

Behaviour:
- Operand inversion:
  - a' = a ^ ainv
  - b' = b ^ binv
- Adder, always computed regardless of opcode:
  - sum = a' ^ b' ^ cin
  - co = (a'&b') | (a'&cin) | (b'&cin)
- Function select on {opcodeA,opcodeB}:
  - 00: a' & b'. ainv=binv=1 gives NOR.
  - 01: a' | b'
  - 10 with binv=0: a' ^ b' (XOR)
  - 10 with binv=1: lessinp (SLT mode)
  - 11: sum. binv=1 with cin=1 gives SUB.
- Flags:
  - ovf = cin ^ co
  - set = sum ^ ovf
  - Both are computed for every opcode and are meaningful only for ADD, SUB and SLT.
- Register update:
  - On rising clk with en=1: cout<=co, result<=fn, overflow<=ovf, slt<=set.
  - en=0: all outputs hold.
- Reset:
  - rst=1 forces cout, result, overflow and slt to 0 immediately, independent of clk.
  - Outputs stay 0 while rst is held; en is ignored.
  - Deassertion mid-operation: first capture happens on the first rising edge with rst=0 and en=1.
- Latency: exactly 1 cycle from input sample to output; no internal state besides the output registers.
- X inputs: no X-suppression is required.

Optional Feature:
- Macro: ALU1_BIT_MSB_STICKY_OVF_EN.
- Defined:
  - Adds input clr_sticky (1 bit) and output ovf_sticky (1 bit).
  - ovf_sticky is set on a rising edge where en=1, opcode=11 and ovf=1.
  - It stays set until clr_sticky=1 at a clock edge or rst=1.
  - If clr_sticky and a set condition coincide, the set wins.
  - Resets to 0.
- Undefined: the ports do not exist, and the logic and all other behaviour are identical.

Test Plan:
- AND: a=1 b=0 cin=0 inv=00 op=00 en=1, one clock -> cout=0 result=0.
- OR and XOR:
  - a=1 b=0 op=01 -> result=1 cout=0.
  - a=0 b=1 binv=0 op=10 -> result=1 cout=0.
- ADD: a=1 b=0 cin=1 op=11 -> cout=1 result=0 overflow=0 slt=0.
- SUB, SLT, NOR:
  - a=1 b=1 binv=1 cin=1 op=11 -> cout=1 result=0.
  - a=0 b=1 binv=1 cin=0 op=10 lessinp=0 -> result=0 cout=0.
  - a=0 b=1 ainv=binv=1 op=00 -> result=0.
- Overflow and set:
  - a=0 b=0 cin=1 op=11 -> result=1 cout=0 overflow=1 slt=0.
  - a=1 b=1 cin=0 op=11 -> result=0 cout=1 overflow=1 slt=1.
- Control:
  - en=0 -> outputs hold across input changes.
  - Assert rst between clock edges -> all outputs 0 without a clock edge.
  - Macro defined: sticky sets on overflow, holds, and clears on clr_sticky.
